// File: rtl/sevenseg_pkg.sv
// Shared glyph table and polarity helper for the seven-segment scanner.
// Patterns are logical (1 = segment lit), bit order {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] GLYPH_SPACE     = 7'h00;
  localparam logic [6:0] GLYPH_HYPHEN    = 7'h40;
  localparam logic [6:0] GLYPH_UNDERLINE = 7'h08;

  // Callers truncate the result to their own width.
  function automatic logic [15:0] apply_pol(input logic [15:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Producer-side load bus and board-side display pins of the scanner.
interface sevenseg_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [PWM_BITS-1:0]     brightness;
  logic                    load;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output digits, dp_mask, blank_mask, blink_mask, brightness, load,
    input  seg, an, dp, frame_start
  );

  modport slave (
    input  digits, dp_mask, blank_mask, blink_mask, brightness, load,
    output seg, an, dp, frame_start
  );
endinterface

// File: rtl/sevenseg_decode.sv
// Hex code to logical seven-segment pattern.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pat
);
  assign pat = HEX_GLYPH[code];
endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with PWM dimming, blink and
// frame-synchronous double-buffered content.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_LOG2 = 15,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_LOG2   = 5,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  sevenseg_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam bit AL = (ACTIVE_LOW != 0);
  localparam logic [6:0]            IDLE_SEG = 7'(apply_pol(16'h0, AL));
  localparam logic [NUM_DIGITS-1:0] IDLE_AN  = NUM_DIGITS'(apply_pol(16'h0, AL));

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dpm;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0]      blink;
    logic [PWM_BITS-1:0]        br;
  } frame_t;

  localparam frame_t RST_FRAME = '{dig: '0, dpm: '0, blank: '1, blink: '0, br: '0};

  frame_t live, pend, act;
  logic   pend_vld;

  logic [REFRESH_LOG2-1:0] presc;
  logic [IW-1:0]           idx;
  logic [BLINK_LOG2-1:0]   frm;
  logic                    blink_ph;
  logic                    tick, last, bnd;
  logic [1:0]              fs_pipe;

  assign live.dig   = bus.digits;
  assign live.dpm   = bus.dp_mask;
  assign live.blank = bus.blank_mask;
  assign live.blink = bus.blink_mask;
  assign live.br    = bus.brightness;

  assign tick = &presc;
  assign last = (idx == IW'(NUM_DIGITS - 1));
  assign bnd  = tick & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      idx      <= '0;
      frm      <= '0;
      blink_ph <= 1'b0;
    end else begin
      presc <= presc + REFRESH_LOG2'(1);
      if (tick) idx <= last ? '0 : idx + IW'(1);
      if (bnd) begin
        frm <= frm + BLINK_LOG2'(1);
        if (&frm) blink_ph <= ~blink_ph;
      end
    end
  end

  // A load landing on the boundary cycle bypasses pending and commits directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= RST_FRAME;
      act      <= RST_FRAME;
      pend_vld <= 1'b0;
    end else begin
      if (bus.load) pend <= live;
      if (bnd && bus.load) begin
        act      <= live;
        pend_vld <= 1'b0;
      end else if (bnd && pend_vld) begin
        act      <= pend;
        pend_vld <= 1'b0;
      end else if (bus.load) begin
        pend_vld <= 1'b1;
      end
    end
  end

  logic [PWM_BITS-1:0]   pwm_ph;
  logic                  pwm_on, dark;
  logic [6:0]            pat, seg_l, seg_n;
  logic [NUM_DIGITS-1:0] an_l, an_n;
  logic                  dp_l, dp_n;

  sevenseg_decode u_dec (.code(act.dig[idx]), .pat(pat));

  assign pwm_ph = presc[REFRESH_LOG2-1 -: PWM_BITS];
  assign pwm_on = (&act.br) | (pwm_ph < act.br);
  assign dark   = act.blank[idx] | (act.blink[idx] & blink_ph) | ~pwm_on;
  assign an_l   = dark ? '0 : (NUM_DIGITS'(1) << idx);
  assign seg_l  = dark ? '0 : pat;
  assign dp_l   = ~dark & act.dpm[idx];
  assign seg_n  = 7'(apply_pol({9'b0, seg_l}, AL));
  assign an_n   = NUM_DIGITS'(apply_pol(16'(an_l), AL));
  assign dp_n   = AL ? ~dp_l : dp_l;

  // fs_pipe delays the boundary by two so the pulse lines up with slot 0's first output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg <= IDLE_SEG;
      bus.an  <= IDLE_AN;
      bus.dp  <= AL;
      fs_pipe <= '0;
    end else begin
      bus.seg <= seg_n;
      bus.an  <= an_n;
      bus.dp  <= dp_n;
      fs_pipe <= {fs_pipe[0], bnd};
    end
  end

  assign bus.frame_start = fs_pipe[1];

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: stimulus queues per-cycle expectations,
// a monitor pops and compares them on the falling edge.
module tb_sevenseg_scan;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sevenseg_if #(.NUM_DIGITS(4), .PWM_BITS(2)) bus_if ();

  sevenseg_scan #(
    .NUM_DIGITS(4), .REFRESH_LOG2(4), .PWM_BITS(2), .BLINK_LOG2(1), .ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc;

  // Active-low glyphs for hex 0..F.
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  // Expected outputs for cycles k0..k1 with the given committed content.
  task automatic push_range(input int k0, input int k1, input logic [15:0] dg, input logic [1:0] br,
                            input logic [3:0] dpm, input logic [3:0] blk);
    for (int k = k0; k <= k1; k++) begin
      exp_t e;
      int   idx, ph;
      logic drk;
      idx  = ((k - 1) / 16) % 4;
      ph   = ((k - 1) % 16) / 4;
      drk  = blk[idx] || (br != 2'd3 && ph >= int'(br));
      e.k  = k;
      e.fs = (k % 64 == 1) && (k > 64);
      if (drk) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an  = ~(4'b0001 << idx);
        e.seg = segtab[dg[idx*4 +: 4]];
        e.dp  = ~dpm[idx];
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_neg(input int k);
    int g = 0;
    @(negedge clk);
    while (cyc < k && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_cycle", k, 16'(cyc), 16'(k));
  endtask

  task automatic load_at(input int k, input logic [15:0] dg, input logic [1:0] br,
                         input logic [3:0] dpm, input logic [3:0] blk, input logic [3:0] bli);
    wait_neg(k - 1);
    bus_if.digits     = dg;
    bus_if.brightness = br;
    bus_if.dp_mask    = dpm;
    bus_if.blank_mask = blk;
    bus_if.blink_mask = bli;
    bus_if.load       = 1'b1;
    wait_neg(k);
    bus_if.load       = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain", cyc, 16'(sb.size()), 16'd0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_an"},  cyc, {12'b0, bus_if.an},  16'h000F);
    chk({nm, "_seg"}, cyc, {9'b0, bus_if.seg},  16'h007F);
    chk({nm, "_dp"},  cyc, {15'b0, bus_if.dp},  16'h0001);
    chk({nm, "_fs"},  cyc, {15'b0, bus_if.frame_start}, 16'h0000);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        while (sb.size() > 0 && sb[0].k < cyc) begin
          exp_t m;
          m = sb.pop_front();
          n_chk++;
          n_fail++;
          $display("FAIL missed_sample cycle %0d: got none expected check at %0d", cyc, m.k);
        end
        if (sb.size() > 0 && sb[0].k == cyc) begin
          exp_t e;
          e = sb.pop_front();
          chk("an",  cyc, {12'b0, bus_if.an},  {12'b0, e.an});
          chk("seg", cyc, {9'b0, bus_if.seg},  {9'b0, e.seg});
          chk("dp",  cyc, {15'b0, bus_if.dp},  {15'b0, e.dp});
          chk("frame_start", cyc, {15'b0, bus_if.frame_start}, {15'b0, e.fs});
        end
      end
    end
  end

  initial begin
    bus_if.digits = '0; bus_if.dp_mask = '0; bus_if.blank_mask = '0;
    bus_if.blink_mask = '0; bus_if.brightness = '0; bus_if.load = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");

    push_range(1, 256, 16'h0, 2'd0, 4'h0, 4'hF);
    push_range(257, 320, 16'h3210, 2'd3, 4'h0, 4'h0);
    push_range(321, 384, 16'h3210, 2'd1, 4'h0, 4'h0);
    push_range(385, 512, 16'h3210, 2'd0, 4'h0, 4'h0);
    rst_n = 1'b1;

    load_at(200, 16'h3210, 2'd3, 4'h0, 4'h0, 4'h0);
    load_at(300, 16'h3210, 2'd1, 4'h0, 4'h0, 4'h0);
    load_at(330, 16'h3210, 2'd0, 4'h0, 4'h0, 4'h0);

    // Mid-frame load during slot 1 must wait for the boundary.
    push_range(513, 576, 16'hFFFF, 2'd3, 4'h0, 4'h0);
    load_at(470, 16'hFFFF, 2'd3, 4'h0, 4'h0, 4'h0);

    // Load on the boundary cycle itself commits for the very next frame.
    push_range(577, 704, 16'hABCD, 2'd3, 4'h0, 4'h0);
    load_at(576, 16'hABCD, 2'd3, 4'h0, 4'h0, 4'h0);

    // Blink phase is 1 for frames 11 and 14, 0 for frames 12 and 13.
    push_range(705, 768, 16'h3210, 2'd3, 4'b0010, 4'b0001);
    push_range(769, 896, 16'h3210, 2'd3, 4'b0010, 4'b0000);
    push_range(897, 960, 16'h3210, 2'd3, 4'b0010, 4'b0001);
    load_at(650, 16'h3210, 2'd3, 4'b0010, 4'b0000, 4'b0001);
    drain();

    // Asynchronous reset in the middle of a lit digit-1 slot.
    wait_neg(980);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    repeat (2) @(negedge clk);
    chk_idle("reset_hold");

    push_range(1, 64, 16'h0, 2'd0, 4'h0, 4'hF);
    push_range(65, 128, 16'h9876, 2'd3, 4'h0, 4'h0);
    rst_n = 1'b1;
    load_at(10, 16'h9876, 2'd3, 4'h0, 4'h0, 4'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
